// File: rtl/cc_tag_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cc_tag_pkg : widths, way sizing, encode/popcount and tree-PLRU helpers    |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
package cc_tag_pkg;

    localparam int TAG_W_DEF    = 18;
    localparam int INDEX_W_DEF  = 8;
    localparam int OFFSET_W_DEF = 6;
    localparam int NUM_WAYS_DEF = 4;
    localparam int MAX_WAYS     = 8;

    // Way-index width; a direct-mapped cache still gets a 1-bit way field.
    function automatic int way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_WAYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int popcount(input logic [MAX_WAYS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

    // Node n has children 2n+1 / 2n+2; a node bit of 1 points the victim walk right.
    function automatic int plru_victim(input logic [MAX_WAYS-2:0] bits, input int levels);
        int node;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) node = 2 * node + 1 + int'(bits[node[2:0]]);
        end
        return node - ((1 << levels) - 1);
    endfunction

    function automatic logic [MAX_WAYS-2:0] plru_update(input logic [MAX_WAYS-2:0] bits,
                                                        input int way, input int levels);
        logic [MAX_WAYS-2:0] r;
        int node;
        int dir;
        r    = bits;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                dir           = (way >> (levels - 1 - l)) & 1;
                r[node[2:0]]  = (dir == 0);
                node          = 2 * node + 1 + dir;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_tag_cmp_nway_plru.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cc_plru_tree : per-set tree pseudo-LRU state with hit/fill update         |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
module cc_plru_tree
    import cc_tag_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int INDEX_W  = 8,
    parameter int WAY_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit_i,
    input  logic [INDEX_W-1:0] hit_index_i,
    input  logic [WAY_W-1:0]   hit_way_i,
    input  logic               fill_i,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic [WAY_W-1:0]   fill_way_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic [WAY_W-1:0]   victim_way_o
);

    localparam int LEVELS   = $clog2(NUM_WAYS);
    localparam int NODES    = NUM_WAYS - 1;
    localparam int NUM_SETS = 1 << INDEX_W;

    logic [NODES-1:0] plru_q [NUM_SETS];
    logic [NODES-1:0] plru_d [NUM_SETS];

    // Fill is applied on top of the hit update so it wins on a shared set.
    always_comb begin
        plru_d = plru_q;
        if (hit_i) begin
            plru_d[hit_index_i] = NODES'(plru_update(7'(plru_q[hit_index_i]),
                                                     int'(hit_way_i), LEVELS));
        end
        if (fill_i) begin
            plru_d[fill_index_i] = NODES'(plru_update(7'(plru_d[fill_index_i]),
                                                      int'(fill_way_i), LEVELS));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

    assign victim_way_o = WAY_W'(plru_victim(7'(plru_q[rd_index_i]), LEVELS));

endmodule
`default_nettype wire

// File: rtl/cc_tag_cmp_nway.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cc_tag_cmp_nway : N-way tag compare, hit/miss/multi-hit, victim select    |
// | Option          : CC_TAG_CMP_PLRU_EN = per-set tree PLRU, else global RR  |
// | Revision        : 1.0                                                     |
// +---------------------------------------------------------------------------+
module cc_tag_cmp_nway
    import cc_tag_pkg::*;
#(
    parameter  int TAG_W    = TAG_W_DEF,
    parameter  int INDEX_W  = INDEX_W_DEF,
    parameter  int OFFSET_W = OFFSET_W_DEF,
    parameter  int NUM_WAYS = NUM_WAYS_DEF,
    localparam int WAY_W    = way_bits(NUM_WAYS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_W-1:0]              tag_i,
    input  logic [INDEX_W-1:0]            index_i,
    input  logic [OFFSET_W-1:0]           offset_i,
    input  logic                          hs_pulse_i,
    input  logic [NUM_WAYS*(TAG_W+1)-1:0] rdata_tag_i,
    input  logic                          fill_i,
    input  logic [INDEX_W-1:0]            fill_index_i,
    input  logic [WAY_W-1:0]              fill_way_i,
    output logic [TAG_W-1:0]              tag_delayed_o,
    output logic [INDEX_W-1:0]            index_delayed_o,
    output logic [OFFSET_W-1:0]           offset_delayed_o,
    output logic                          hs_pulse_delayed_o,
    output logic                          hit_o,
    output logic                          miss_o,
    output logic [WAY_W-1:0]              hit_way_o,
    output logic [WAY_W-1:0]              victim_way_o,
    output logic                          multi_hit_err_o
);

    logic [TAG_W-1:0]    tag_q,    tag_d;
    logic [INDEX_W-1:0]  index_q,  index_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                pulse_q,  pulse_d;

    always_comb begin
        tag_d    = hs_pulse_i ? tag_i    : tag_q;
        index_d  = hs_pulse_i ? index_i  : index_q;
        offset_d = hs_pulse_i ? offset_i : offset_q;
        pulse_d  = hs_pulse_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            index_q  <= index_d;
            offset_q <= offset_d;
            pulse_q  <= pulse_d;
        end
    end

    assign tag_delayed_o      = tag_q;
    assign index_delayed_o    = index_q;
    assign offset_delayed_o   = offset_q;
    assign hs_pulse_delayed_o = pulse_q;

    logic [NUM_WAYS-1:0] valid;
    logic [NUM_WAYS-1:0] match;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign valid[w] = rdata_tag_i[w*(TAG_W+1) + TAG_W];
        assign match[w] = valid[w] && (rdata_tag_i[w*(TAG_W+1) +: TAG_W] == tag_q);
    end

    assign hit_o           = pulse_q & (|match);
    assign miss_o          = pulse_q & ~(|match);
    assign multi_hit_err_o = pulse_q && (popcount(8'(match)) > 1);

    if (NUM_WAYS == 1) begin : g_single
        logic unused_fill;
        assign unused_fill  = ^{fill_i, fill_index_i, fill_way_i};
        assign hit_way_o    = '0;
        assign victim_way_o = '0;
    end else begin : g_assoc
        logic [WAY_W-1:0] policy_way;
        logic [WAY_W-1:0] free_way;

        assign hit_way_o    = hit_o ? WAY_W'(onehot_to_idx(8'(match))) : '0;
        assign free_way     = WAY_W'(onehot_to_idx(8'(~valid)));
        // Empty ways are always preferred over evicting a live line.
        assign victim_way_o = (&valid) ? policy_way : free_way;

`ifdef CC_TAG_CMP_PLRU_EN
        cc_plru_tree #(
            .NUM_WAYS (NUM_WAYS),
            .INDEX_W  (INDEX_W),
            .WAY_W    (WAY_W)
        ) u_plru (
            .clk          (clk),
            .rst_n        (rst_n),
            .hit_i        (hit_o),
            .hit_index_i  (index_q),
            .hit_way_i    (hit_way_o),
            .fill_i       (fill_i),
            .fill_index_i (fill_index_i),
            .fill_way_i   (fill_way_i),
            .rd_index_i   (index_q),
            .victim_way_o (policy_way)
        );
`else
        logic [WAY_W-1:0] rr_q, rr_d;
        logic             unused_fill;

        assign unused_fill = ^{fill_index_i, fill_way_i};

        always_comb begin
            rr_d = rr_q;
            if (fill_i) rr_d = (rr_q == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) rr_q <= '0;
            else        rr_q <= rr_d;
        end

        assign policy_way = rr_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cc_tag_cmp_nway.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_cc_tag_cmp_nway : directed vectors for the N-way tag comparator        |
// | Revision           : 1.0                                                  |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cc_tag_cmp_nway;

    localparam int TAG_W    = 18;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 6;
    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;
    localparam int RD_W     = NUM_WAYS * (TAG_W + 1);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [TAG_W-1:0]    tag_i;
    logic [INDEX_W-1:0]  index_i;
    logic [OFFSET_W-1:0] offset_i;
    logic                hs_pulse_i;
    logic [RD_W-1:0]     rdata_tag_i;
    logic                fill_i;
    logic [INDEX_W-1:0]  fill_index_i;
    logic [WAY_W-1:0]    fill_way_i;
    logic [TAG_W-1:0]    tag_delayed_o;
    logic [INDEX_W-1:0]  index_delayed_o;
    logic [OFFSET_W-1:0] offset_delayed_o;
    logic                hs_pulse_delayed_o;
    logic                hit_o;
    logic                miss_o;
    logic [WAY_W-1:0]    hit_way_o;
    logic [WAY_W-1:0]    victim_way_o;
    logic                multi_hit_err_o;

    cc_tag_cmp_nway #(
        .TAG_W    (TAG_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .NUM_WAYS (NUM_WAYS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tag_i              (tag_i),
        .index_i            (index_i),
        .offset_i           (offset_i),
        .hs_pulse_i         (hs_pulse_i),
        .rdata_tag_i        (rdata_tag_i),
        .fill_i             (fill_i),
        .fill_index_i       (fill_index_i),
        .fill_way_i         (fill_way_i),
        .tag_delayed_o      (tag_delayed_o),
        .index_delayed_o    (index_delayed_o),
        .offset_delayed_o   (offset_delayed_o),
        .hs_pulse_delayed_o (hs_pulse_delayed_o),
        .hit_o              (hit_o),
        .miss_o             (miss_o),
        .hit_way_o          (hit_way_o),
        .victim_way_o       (victim_way_o),
        .multi_hit_err_o    (multi_hit_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RD_W-1:0] mk_rd(input logic [3:0] v,
                                             input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                                             input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3);
        return {v[3], t3, v[2], t2, v[1], t1, v[0], t0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse one request, present the tag-SRAM data in the result cycle, stop at its negedge.
    task automatic lookup(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] idx,
                          input logic [OFFSET_W-1:0] off, input logic [RD_W-1:0] rd);
        tag_i      = t;
        index_i    = idx;
        offset_i   = off;
        hs_pulse_i = 1'b1;
        step();
        hs_pulse_i  = 1'b0;
        rdata_tag_i = rd;
        @(negedge clk);
    endtask

    task automatic fill(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way);
        fill_i       = 1'b1;
        fill_index_i = idx;
        fill_way_i   = way;
        step();
        fill_i = 1'b0;
    endtask

    logic [RD_W-1:0] rd_full;
    logic [RD_W-1:0] rd_set7;

    initial begin
        rd_full = mk_rd(4'b1111, 18'h00001, 18'h00002, 18'h00003, 18'h00004);
        rd_set7 = mk_rd(4'b1111, 18'h00011, 18'h00022, 18'h00033, 18'h00044);

        // Reset with a live pulse and fully valid, matching tag data
        rst_n        = 1'b0;
        hs_pulse_i   = 1'b1;
        tag_i        = 18'h3FFFF;
        index_i      = 8'hFF;
        offset_i     = 6'h3F;
        rdata_tag_i  = mk_rd(4'b1111, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
        fill_i       = 1'b0;
        fill_index_i = '0;
        fill_way_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tag_d",   32'(tag_delayed_o),      32'h0);
        chk("rst_index_d", 32'(index_delayed_o),    32'h0);
        chk("rst_off_d",   32'(offset_delayed_o),   32'h0);
        chk("rst_pulse_d", 32'(hs_pulse_delayed_o), 32'h0);
        chk("rst_hit",     32'(hit_o),              32'h0);
        chk("rst_miss",    32'(miss_o),             32'h0);
        chk("rst_err",     32'(multi_hit_err_o),    32'h0);
        chk("rst_victim",  32'(victim_way_o),       32'h0);

        rst_n       = 1'b1;
        tag_i       = 18'h12345;
        rdata_tag_i = '0;
        #1;
        chk("rel_nohit",  32'(hit_o),  32'h0);
        chk("rel_nomiss", 32'(miss_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_miss",    32'(miss_o),             32'h1);
        chk("rel_pulse_d", 32'(hs_pulse_delayed_o), 32'h1);
        chk("rel_tag_d",   32'(tag_delayed_o),      32'h12345);
        hs_pulse_i = 1'b0;
        step();

        // Single hit in way 2
        lookup(18'h2A5F3, 8'h11, 6'h15, mk_rd(4'b0100, 18'h0, 18'h0, 18'h2A5F3, 18'h0));
        chk("hit_hit",     32'(hit_o),              32'h1);
        chk("hit_miss",    32'(miss_o),             32'h0);
        chk("hit_way",     32'(hit_way_o),          32'h2);
        chk("hit_err",     32'(multi_hit_err_o),    32'h0);
        chk("hit_tag_d",   32'(tag_delayed_o),      32'h2A5F3);
        chk("hit_index_d", 32'(index_delayed_o),    32'h11);
        chk("hit_off_d",   32'(offset_delayed_o),   32'h15);
        chk("hit_pulse_d", 32'(hs_pulse_delayed_o), 32'h1);
        step();
        @(negedge clk);
        chk("hold_tag_d",   32'(tag_delayed_o),   32'h2A5F3);
        chk("hold_index_d", 32'(index_delayed_o), 32'h11);
        chk("idle_hit",     32'(hit_o),           32'h0);
        chk("idle_miss",    32'(miss_o),          32'h0);
        step();

        // Miss with way 1 empty
        lookup(18'h00ABC, 8'h22, 6'h00, mk_rd(4'b1101, 18'h1, 18'h2, 18'h3, 18'h4));
        chk("mis_miss",   32'(miss_o),       32'h1);
        chk("mis_hit",    32'(hit_o),        32'h0);
        chk("mis_victim", 32'(victim_way_o), 32'h1);
        chk("mis_hitway", 32'(hit_way_o),    32'h0);
        step();

        // Ways 0 and 3 match; invalid way 2 carries the same tag and must be ignored
        lookup(18'h15555, 8'h33, 6'h01, mk_rd(4'b1011, 18'h15555, 18'h00001, 18'h15555, 18'h15555));
        chk("mh_hit", 32'(hit_o),           32'h1);
        chk("mh_way", 32'(hit_way_o),       32'h0);
        chk("mh_err", 32'(multi_hit_err_o), 32'h1);
        step();

        // Replacement policy on set 5, all ways valid
        fill(8'd5, 2'd0);
        fill(8'd5, 2'd1);
        fill(8'd5, 2'd2);
`ifdef CC_TAG_CMP_PLRU_EN
        fill(8'd5, 2'd3);
        lookup(18'h03000, 8'd5, 6'h00, rd_full);
        chk("plru_miss",  32'(miss_o),       32'h1);
        chk("plru_vic_a", 32'(victim_way_o), 32'h0);
        step();
        lookup(18'h00001, 8'd5, 6'h00, rd_full);
        chk("plru_hit0", 32'(hit_way_o), 32'h0);
        step();
        lookup(18'h03000, 8'd5, 6'h00, rd_full);
        chk("plru_vic_b", 32'(victim_way_o), 32'h2);
        step();
`else
        lookup(18'h03000, 8'd5, 6'h00, rd_full);
        chk("rr_miss",  32'(miss_o),       32'h1);
        chk("rr_vic_3", 32'(victim_way_o), 32'h3);
        step();
        fill(8'd5, 2'd3);
        lookup(18'h03000, 8'd5, 6'h00, rd_full);
        chk("rr_vic_wrap", 32'(victim_way_o), 32'h0);
        step();
        lookup(18'h00001, 8'd5, 6'h00, rd_full);
        chk("rr_hit0", 32'(hit_way_o), 32'h0);
        step();
        lookup(18'h03000, 8'd5, 6'h00, rd_full);
        chk("rr_hit_noeff", 32'(victim_way_o), 32'h0);
        step();
`endif

        // Hit way 1 and fill way 3 on set 7 in the same cycle
        lookup(18'h00022, 8'd7, 6'h00, rd_set7);
        fill_i       = 1'b1;
        fill_index_i = 8'd7;
        fill_way_i   = 2'd3;
        chk("sim_hit_way", 32'(hit_way_o), 32'h1);
        step();
        fill_i = 1'b0;
        lookup(18'h03000, 8'd7, 6'h00, rd_set7);
`ifdef CC_TAG_CMP_PLRU_EN
        chk("sim_victim", 32'(victim_way_o), 32'h0);
`else
        chk("sim_victim", 32'(victim_way_o), 32'h1);
`endif
        step();

        // Back-to-back lookups on sets 7 and 8
        tag_i      = 18'h00022;
        index_i    = 8'd7;
        hs_pulse_i = 1'b1;
        step();
        tag_i       = 18'h0ABCD;
        index_i     = 8'd8;
        rdata_tag_i = rd_set7;
        @(negedge clk);
        chk("b2b_hit",   32'(hit_o),           32'h1);
        chk("b2b_way",   32'(hit_way_o),       32'h1);
        chk("b2b_idx_a", 32'(index_delayed_o), 32'h7);
        step();
        hs_pulse_i  = 1'b0;
        rdata_tag_i = rd_full;
        @(negedge clk);
        chk("b2b_miss",    32'(miss_o),             32'h1);
        chk("b2b_pulse_d", 32'(hs_pulse_delayed_o), 32'h1);
        chk("b2b_idx_b",   32'(index_delayed_o),    32'h8);
        chk("b2b_tag_b",   32'(tag_delayed_o),      32'h0ABCD);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
